reg_file_bypass: RTL and testbench
==================================

// Module: reg_file_bypass
// PURPOSE
// - CPU register file: NUM_REGS x WIDTH storage for the decode stage.
// - Built from resettableGenerator rows, one enable-gated row per register.
// - Consumes the writeback result and feeds the two ALU/store operands.
// - Same-cycle write-to-read bypass: decode sees the value writeback is committing without a stall.
// PARAMETERS
// WIDTH     64  data width of each register
// NUM_REGS  32  register count; power of 2; address width AW = log2(NUM_REGS)
// ZERO_REG  31  index hardwired to zero (X31/XZR); writes ignored
// BYPASS    1   1 = write-through forwarding on reads; 0 = reads return stored value only
// PORTS
// clk        in   1      system clock, rising-edge
// reset      in   1      asynchronous, active-high; clears all registers
// reg_write  in   1      write enable from writeback stage
// wr_addr    in   AW     destination register index
// wr_data    in   WIDTH  writeback value
// rd_addr1   in   AW     read port 1 index (Rn)
// rd_addr2   in   AW     read port 2 index (Rm/Rt)
// rd_data1   out  WIDTH  read port 1 data
// rd_data2   out  WIDTH  read port 2 data
// BEHAVIOUR
// - Storage: row r loads wr_data on posedge clk iff reg_write && wr_addr==r && r!=ZERO_REG.
//   All other rows hold (en=0). Write decode is one-hot: at most one row enabled per cycle.
// - Reset: asynchronous. On reset=1, every row is 0 immediately, without waiting for clk.
//   Writes are blocked while reset=1. The first write is accepted on the first posedge after deassertion.
// - Reads are combinational, zero latency:
//   - rd_addrN==ZERO_REG: output 0 always, regardless of bypass or stored contents.
//   - BYPASS=1 && reg_write && wr_addr==rd_addrN && rd_addrN!=ZERO_REG && !reset: output wr_data.
//   - Otherwise: output the stored row value.
// - Both ports are independent. Both may address the same register and both may bypass in the same cycle.
// - Reset output values: rd_data1 = rd_data2 = 0 while reset=1, for every address.
//   Bypass is suppressed during reset.
// - Write latency: the value is stored at the posedge. With BYPASS=1 it is visible to reads in the same cycle.
//   With BYPASS=0 it is visible after the posedge.
// - Boundaries:
//   - Back-to-back writes to the same register: the last write wins; each is visible per the rules above.
//   - Reset asserted mid-write (before the posedge): the write is lost and the register reads 0.
//   - X/unknown wr_addr while reg_write=0: no row changes.
//   - reg_write=1 to ZERO_REG: no state change and no bypass.
// - No arithmetic. No wrap: the address range is exactly NUM_REGS.
// TESTING
// 1 Reset: pulse reset mid-cycle (no clk edge) -> all 32 regs read 0 on both ports immediately.
// 2 Write/read: write X5=64'h0123_4567_89AB_CDEF, then rd_addr1=5 next cycle
//   -> rd_data1 = 64'h0123_4567_89AB_CDEF; X6 still 0.
// 3 Zero reg: reg_write=1, wr_addr=31, wr_data=64'hFFFF...F -> rd_data1/2 at addr 31 = 0,
//   both in the same cycle and after.
// 4 Bypass: wr_addr=7, wr_data=550, reg_write=1, rd_addr1=rd_addr2=7 in the same cycle
//   -> both ports read 550 before the edge. Repeat with BYPASS=0 -> old value before the edge, 550 after.
// 5 Disabled write: reg_write=0, wr_addr=9, wr_data=420 for 3 cycles -> X9 keeps its prior value (69).
// 6 Reset mid-op: X2=215687 stored; assert reset with reg_write=1, wr_addr=2, wr_data=9854768
//   -> X2 reads 0 during and after reset, never 9854768.
//   After deassertion, a write of 1 to X2 reads back 1.

Source files
------------

// File: rtl/reg_file_bypass_if.sv
// rtl/reg_file_bypass_if.sv - write/read port bundle for reg_file_bypass
interface reg_file_bypass_if #(
    parameter int WIDTH = 64,
    parameter int AW    = 5
);
    logic             reg_write;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    rd_addr1;
    logic [AW-1:0]    rd_addr2;
    logic [WIDTH-1:0] rd_data1;
    logic [WIDTH-1:0] rd_data2;

    modport master (
        output reg_write, wr_addr, wr_data, rd_addr1, rd_addr2,
        input  rd_data1, rd_data2
    );

    modport slave (
        input  reg_write, wr_addr, wr_data, rd_addr1, rd_addr2,
        output rd_data1, rd_data2
    );
endinterface

// File: rtl/reg_file_bypass.sv
// rtl/reg_file_bypass.sv - register file with hardwired zero register and write-through read bypass
module reg_file_bypass #(
    parameter int WIDTH    = 64,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 31,
    parameter bit BYPASS   = 1'b1
) (
    input logic           clk,
    input logic           reset,
    reg_file_bypass_if.slave bus
);
    localparam int AW = $clog2(NUM_REGS);
    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic [WIDTH-1:0] row_d;
    logic [WIDTH-1:0] row_val [NUM_REGS];
    logic [WIDTH-1:0] rd1, rd2;
    logic             bypass1, bypass2;

    assign row_d = bus.wr_data;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_row
        if (r == ZERO_REG) begin : g_zero
            assign row_val[r] = '0;
        end else begin : g_store
            logic [WIDTH-1:0] data_q;
            logic             row_en;

            // A reg_write of 0 masks any unknown wr_addr, so an X address cannot disturb a row.
            assign row_en = bus.reg_write && (bus.wr_addr == AW'(r));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_q <= '0;
                end else if (row_en) begin
                    data_q <= row_d;
                end
            end

            assign row_val[r] = data_q;
        end
    end

    assign bypass1 = BYPASS && bus.reg_write && (bus.wr_addr == bus.rd_addr1);
    assign bypass2 = BYPASS && bus.reg_write && (bus.wr_addr == bus.rd_addr2);

    // Zero register and reset take priority over forwarding.
    always_comb begin
        rd1 = row_val[bus.rd_addr1];
        if (reset || bus.rd_addr1 == ZERO_ADDR) begin
            rd1 = '0;
        end else if (bypass1) begin
            rd1 = bus.wr_data;
        end
    end

    always_comb begin
        rd2 = row_val[bus.rd_addr2];
        if (reset || bus.rd_addr2 == ZERO_ADDR) begin
            rd2 = '0;
        end else if (bypass2) begin
            rd2 = bus.wr_data;
        end
    end

    assign bus.rd_data1 = rd1;
    assign bus.rd_data2 = rd2;
endmodule

// File: tb/tb_reg_file_bypass.sv
// tb/tb_reg_file_bypass.sv - directed scoreboard bench for reg_file_bypass (bypass and non-bypass instances)
module tb_reg_file_bypass;
    localparam int WIDTH    = 64;
    localparam int NUM_REGS = 32;
    localparam int AW       = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_file_bypass_if #(.WIDTH(WIDTH), .AW(AW)) bus_a ();
    reg_file_bypass_if #(.WIDTH(WIDTH), .AW(AW)) bus_b ();

    reg_file_bypass #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .ZERO_REG(31), .BYPASS(1'b1)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave)
    );
    reg_file_bypass #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .ZERO_REG(31), .BYPASS(1'b0)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave)
    );

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] exp_q [$];

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd,
                         input logic [AW-1:0] ra1, input logic [AW-1:0] ra2);
        bus_a.reg_write = we; bus_a.wr_addr = wa; bus_a.wr_data = wd;
        bus_a.rd_addr1 = ra1; bus_a.rd_addr2 = ra2;
        bus_b.reg_write = we; bus_b.wr_addr = wa; bus_b.wr_data = wd;
        bus_b.rd_addr1 = ra1; bus_b.rd_addr2 = ra2;
    endtask

    task automatic push4(input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] a2,
                         input logic [WIDTH-1:0] b1, input logic [WIDTH-1:0] b2);
        exp_q.push_back(a1); exp_q.push_back(a2);
        exp_q.push_back(b1); exp_q.push_back(b2);
    endtask

    task automatic pop_check(input string tag, input logic [WIDTH-1:0] obs);
        logic [WIDTH-1:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s: observed %h expected <scoreboard empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic check4(input string tag);
        pop_check({tag, "_a1"}, bus_a.rd_data1);
        pop_check({tag, "_a2"}, bus_a.rd_data2);
        pop_check({tag, "_b1"}, bus_b.rd_data1);
        pop_check({tag, "_b2"}, bus_b.rd_data2);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, '0, '0, 5'd0, 5'd1);
        #1;
        push4(0, 0, 0, 0); check4("rst_init");
        #10;
        reset = 1'b0;
        step();

        // Populate a few rows so the mid-cycle reset has something to clear.
        drive(1'b1, 5'd1, 64'hAAAA_0000_0000_0001, 5'd1, 5'd3);
        step();
        drive(1'b1, 5'd3, 64'hBBBB_0000_0000_0003, 5'd1, 5'd3);
        step();
        drive(1'b0, '0, '0, 5'd1, 5'd3); #1;
        push4(64'hAAAA_0000_0000_0001, 64'hBBBB_0000_0000_0003,
              64'hAAAA_0000_0000_0001, 64'hBBBB_0000_0000_0003);
        check4("pre_rst");

        reset = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
            drive(1'b0, '0, '0, 5'(i), 5'(NUM_REGS - 1 - i));
            #1;
            push4(0, 0, 0, 0); check4($sformatf("rst_sweep%0d", i));
        end
        #2;
        reset = 1'b0;
        step();

        // Write X5, read it back next cycle; X6 untouched.
        drive(1'b1, 5'd5, 64'h0123_4567_89AB_CDEF, 5'd6, 5'd0); #1;
        push4(0, 0, 0, 0); check4("wr5_same");
        step();
        drive(1'b0, '0, '0, 5'd5, 5'd6); #1;
        push4(64'h0123_4567_89AB_CDEF, 0, 64'h0123_4567_89AB_CDEF, 0); check4("wr5_after");

        // Zero register write ignored, no bypass.
        drive(1'b1, 5'd31, '1, 5'd31, 5'd31); #1;
        push4(0, 0, 0, 0); check4("zero_same");
        step();
        drive(1'b0, '0, '0, 5'd31, 5'd31); #1;
        push4(0, 0, 0, 0); check4("zero_after");

        // Bypass versus stored value.
        drive(1'b1, 5'd7, 64'd100, 5'd7, 5'd7);
        step();
        drive(1'b1, 5'd7, 64'd550, 5'd7, 5'd7); #1;
        push4(64'd550, 64'd550, 64'd100, 64'd100); check4("byp_same");
        step();
        drive(1'b0, '0, '0, 5'd7, 5'd7); #1;
        push4(64'd550, 64'd550, 64'd550, 64'd550); check4("byp_after");

        // Disabled write holds prior value.
        drive(1'b1, 5'd9, 64'd69, 5'd9, 5'd5);
        step();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 5'd9, 64'd420, 5'd9, 5'd9); #1;
            push4(64'd69, 64'd69, 64'd69, 64'd69); check4($sformatf("nowr%0d", c));
            step();
        end

        // Back-to-back writes to one register.
        drive(1'b1, 5'd10, 64'd11, 5'd10, 5'd0);
        step();
        drive(1'b1, 5'd10, 64'd22, 5'd10, 5'd0); #1;
        push4(64'd22, 0, 64'd11, 0); check4("b2b_same");
        step();
        drive(1'b0, '0, '0, 5'd10, 5'd7); #1;
        push4(64'd22, 64'd550, 64'd22, 64'd550); check4("b2b_after");

        // Unknown address with write disabled changes nothing.
        drive(1'b0, 'x, 64'hDEAD, 5'd5, 5'd9);
        step(); #1;
        push4(64'h0123_4567_89AB_CDEF, 64'd69, 64'h0123_4567_89AB_CDEF, 64'd69); check4("xaddr");

        // Reset arriving mid-write loses the write.
        drive(1'b1, 5'd2, 64'd215687, 5'd0, 5'd1);
        step();
        drive(1'b1, 5'd2, 64'd9854768, 5'd2, 5'd2); #1;
        push4(64'd9854768, 64'd9854768, 64'd215687, 64'd215687); check4("rmid_pre");
        reset = 1'b1; #1;
        push4(0, 0, 0, 0); check4("rmid_during");
        step();
        push4(0, 0, 0, 0); check4("rmid_edge");
        drive(1'b0, '0, '0, 5'd2, 5'd2); #1;
        reset = 1'b0; #1;
        push4(0, 0, 0, 0); check4("rmid_after");
        drive(1'b1, 5'd2, 64'd1, 5'd2, 5'd5);
        step();
        drive(1'b0, '0, '0, 5'd2, 5'd5); #1;
        push4(64'd1, 0, 64'd1, 0); check4("rmid_rewrite");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
